// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared elaboration-time helpers for the parameterised sequence detector.
// Holds the mode / overlap constant names and the functions that turn a
// PATTERN value into its KMP prefix-failure and next-state (delta) tables.
// Pattern bits are numbered in arrival order: bit j of the sequence is
// PATTERN[PAT_W-1-j], so PATTERN[PAT_W-1] is the first bit received.
package seq_det_pkg;

  localparam int MODE_MOORE  = 0;
  localparam int MODE_MEALY  = 1;
  localparam int OVERLAP_OFF = 0;
  localparam int OVERLAP_ON  = 1;
  localparam int MAX_PAT_W   = 16;

  // Bit j of the sequence in arrival order. A shift is used so that the
  // select never needs a narrowed index.
  function automatic logic pat_bit(input logic [15:0] pat, input int w, input int j);
    logic [15:0] sh;
    sh = pat >> (w - 1 - j);
    return sh[0];
  endfunction

  // Length of the longest proper prefix of the first k pattern bits that is
  // also a suffix of them (classic KMP failure value, k in 1..w).
  function automatic int failure(input logic [15:0] pat, input int w, input int k);
    int  res;
    logic ok;
    res = 0;
    for (int len = MAX_PAT_W - 1; len >= 1; len--) begin
      if (res == 0 && len < k) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_PAT_W; j++) begin
          if (j < len) begin
            if (pat_bit(pat, w, j) != pat_bit(pat, w, k - len + j)) ok = 1'b0;
          end
        end
        if (ok) res = len;
      end
    end
    return res;
  endfunction

  // Next prefix length after seeing bit b in prefix state s (s in 0..w).
  // Extends on a matching bit, otherwise walks down the failure chain.
  function automatic int delta(input logic [15:0] pat, input int w, input int s, input logic b);
    int   cur;
    int   res;
    logic done;
    cur  = s;
    res  = 0;
    done = 1'b0;
    for (int it = 0; it <= MAX_PAT_W; it++) begin
      if (!done) begin
        if (cur < w) begin
          if (pat_bit(pat, w, cur) == b) begin
            res  = cur + 1;
            done = 1'b1;
          end
        end
        if (!done) begin
          if (cur == 0) begin
            res  = 0;
            done = 1'b1;
          end else begin
            cur = failure(pat, w, cur);
          end
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter for detected matches.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset, clears the count
//   inc   : add one this cycle (ignored once all-ones)
//   clr   : synchronous clear, wins over inc
//   count : current count
//   sat   : high while count is all-ones
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear has priority; increment stops at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = &count_q;

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial pattern detector built on a KMP automaton whose tables are derived
// from PATTERN at elaboration. Supports overlapping / restarting matches and
// Mealy (same-cycle) or Moore (registered) match pulses, plus a saturating
// match counter.
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset
//   in          : serial data bit
//   in_valid    : in is accepted only while high
//   clear       : synchronous restart of detector and counter
//   out         : one-cycle match pulse
//   match_count : matches since reset/clear (saturating)
//   count_sat   : high while match_count is all-ones
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
  parameter int               OVERLAP = OVERLAP_ON,
  parameter int               MEALY   = MODE_MEALY,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int              SW        = $clog2(PAT_W + 1);
  localparam logic [15:0]     PAT16     = 16'(PATTERN);
  localparam int              RESTART   = (OVERLAP == OVERLAP_ON) ? failure(PAT16, PAT_W, PAT_W) : 0;
  localparam logic [SW-1:0]   MATCH_S   = SW'(PAT_W);
  localparam logic [SW-1:0]   RESTART_S = SW'(RESTART);

  // Next-state tables indexed by prefix length, one per input bit value.
  logic [SW-1:0] next0_tab [PAT_W+1];
  logic [SW-1:0] next1_tab [PAT_W+1];

  for (genvar s = 0; s <= PAT_W; s++) begin : g_delta
    localparam int N0 = delta(PAT16, PAT_W, s, 1'b0);
    localparam int N1 = delta(PAT16, PAT_W, s, 1'b1);
    assign next0_tab[s] = SW'(N0);
    assign next1_tab[s] = SW'(N1);
  end

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic [SW-1:0] base_s;
  logic [SW-1:0] next_s;
  logic          match_now;

  // Only the Moore detector ever parks in the full-match state; leaving it
  // behaves as if we were already at the restart prefix, which also makes
  // an idle cycle drop the state so the pulse stays one cycle wide.
  // A clear on the same cycle as a match suppresses both pulse and count.
  always_comb begin
    base_s = state_q;
    if (state_q == MATCH_S) begin
      base_s = RESTART_S;
    end
    next_s    = in ? next1_tab[base_s] : next0_tab[base_s];
    match_now = in_valid && !clear && (next_s == MATCH_S);

    state_d = base_s;
    if (clear) begin
      state_d = '0;
    end else if (in_valid) begin
      if (MEALY == MODE_MEALY && next_s == MATCH_S) begin
        state_d = RESTART_S;
      end else begin
        state_d = next_s;
      end
    end

    if (MEALY == MODE_MEALY) begin
      out = rst && match_now;
    end else begin
      out = (state_q == MATCH_S);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // A match in either mode is counted on the edge that completes it.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (match_now),
    .clr  (clear),
    .count(match_count),
    .sat  (count_sat)
  );

endmodule
